// File: rtl/uart_pkg.sv
// Shared types and defaults for the UART transmit scheduler.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    READY = 3'd2,
    START = 3'd3,
    WAIT  = 3'd4
  } uart_state_e;

  localparam int unsigned FRAME_CYCLES_DEF = 160;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; the favoured pointer flips away from each winner on advance.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_b,
  input  logic [1:0] valid,
  input  logic       advance,
  output logic [1:0] grant
);

  logic fav_q, fav_d;  // 1: requester 1 wins a tie

  always_comb begin
    grant = 2'b00;
    case (valid)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = fav_q ? 2'b10 : 2'b01;
      default: grant = 2'b00;
    endcase
    fav_d = fav_q;
    if (advance && (grant != 2'b00)) fav_d = grant[0];
  end

  always_ff @(posedge clk) begin
    if (rst_b) fav_q <= 1'b0;
    else       fav_q <= fav_d;
  end

endmodule

// File: rtl/uart_tx_sched.sv
// Arbitrates two byte requesters onto a UART transmitter and paces frames.
// Optional build macro UART_TX_SCHED_CNT_EN adds a 16-bit count of sent bytes (tx_count).
module uart_tx_sched
  import uart_pkg::*;
#(
  parameter int unsigned FRAME_CYCLES = FRAME_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        rst_b,
  input  logic        req0_valid,
  input  logic [7:0]  req0_data,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [7:0]  req1_data,
  output logic        req1_ready,
  output logic [7:0]  data_bus,
  output logic        load_xmt_datareg,
  output logic        byte_ready,
  output logic        t_byte,
  output logic        busy,
  output logic        grant_id
`ifdef UART_TX_SCHED_CNT_EN
  ,
  output logic [15:0] tx_count
`endif
);

  uart_state_e state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [7:0]  data_q, data_d;
  logic        gid_q, gid_d;
  logic [1:0]  grant, ready_vec;
  logic        advance;

  rr_arb2 u_arb (
    .clk     (clk),
    .rst_b   (rst_b),
    .valid   ({req1_valid, req0_valid}),
    .advance (advance),
    .grant   (grant)
  );

  // Acceptance is suppressed during reset so nothing is handed over on a reset edge.
  assign ready_vec = ((state_q == IDLE) && !rst_b) ? grant : 2'b00;
  assign advance   = |ready_vec;

  always_comb begin
    state_d          = state_q;
    cnt_d            = cnt_q;
    data_d           = data_q;
    gid_d            = gid_q;
    load_xmt_datareg = 1'b0;
    byte_ready       = 1'b0;
    t_byte           = 1'b0;
    case (state_q)
      IDLE: begin
        if (advance) begin
          data_d  = ready_vec[1] ? req1_data : req0_data;
          gid_d   = ready_vec[1];
          state_d = LOAD;
        end
      end
      LOAD: begin
        load_xmt_datareg = 1'b1;
        state_d          = READY;
      end
      READY: begin
        byte_ready = 1'b1;
        state_d    = START;
      end
      START: begin
        t_byte  = 1'b1;
        cnt_d   = 16'(FRAME_CYCLES - 1);
        state_d = WAIT;
      end
      WAIT: begin
        if (cnt_q == 16'd0) state_d = IDLE;
        else                cnt_d   = cnt_q - 16'd1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_b) begin
      state_q <= IDLE;
      cnt_q   <= 16'd0;
      data_q  <= 8'h00;
      gid_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      gid_q   <= gid_d;
    end
  end

  assign req0_ready = ready_vec[0];
  assign req1_ready = ready_vec[1];
  assign data_bus   = data_q;
  assign grant_id   = gid_q;
  assign busy       = (state_q != IDLE);

`ifdef UART_TX_SCHED_CNT_EN
  logic [15:0] tx_cnt_q;

  always_ff @(posedge clk) begin
    if (rst_b)                 tx_cnt_q <= 16'd0;
    else if (state_q == START) tx_cnt_q <= tx_cnt_q + 16'd1;
  end

  assign tx_count = tx_cnt_q;
`endif

endmodule

// File: tb/tb_uart_tx_sched.sv
// Directed bench for uart_tx_sched with FRAME_CYCLES=8 and FRAME_CYCLES=1 instances.
module tb_uart_tx_sched;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_b;
  logic       a_v0, a_v1, a_r0, a_r1, a_load, a_br, a_tb, a_busy, a_gid;
  logic [7:0] a_d0, a_d1, a_bus;
  logic       b_v0, b_v1, b_r0, b_r1, b_load, b_br, b_tb, b_busy, b_gid;
  logic [7:0] b_d0, b_d1, b_bus;
`ifdef UART_TX_SCHED_CNT_EN
  logic [15:0] a_txc, b_txc;
`endif

  int checks = 0;
  int errors = 0;

  uart_tx_sched #(.FRAME_CYCLES(8)) u_d8 (
    .clk(clk), .rst_b(rst_b),
    .req0_valid(a_v0), .req0_data(a_d0), .req0_ready(a_r0),
    .req1_valid(a_v1), .req1_data(a_d1), .req1_ready(a_r1),
    .data_bus(a_bus), .load_xmt_datareg(a_load), .byte_ready(a_br),
    .t_byte(a_tb), .busy(a_busy), .grant_id(a_gid)
`ifdef UART_TX_SCHED_CNT_EN
    , .tx_count(a_txc)
`endif
  );

  uart_tx_sched #(.FRAME_CYCLES(1)) u_d1 (
    .clk(clk), .rst_b(rst_b),
    .req0_valid(b_v0), .req0_data(b_d0), .req0_ready(b_r0),
    .req1_valid(b_v1), .req1_data(b_d1), .req1_ready(b_r1),
    .data_bus(b_bus), .load_xmt_datareg(b_load), .byte_ready(b_br),
    .t_byte(b_tb), .busy(b_busy), .grant_id(b_gid)
`ifdef UART_TX_SCHED_CNT_EN
    , .tx_count(b_txc)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  initial begin
    int nb, nl, nbr, nt, ndb, il, ibr, it, n, both, bad, found;
    logic [7:0] bytes [4];
    logic       gids  [4];
    int         pos   [3];

    rst_b = 1'b1;
    a_v0 = 1'b1; a_v1 = 1'b0; a_d0 = 8'h99; a_d1 = 8'h00;
    b_v0 = 1'b0; b_v1 = 1'b0; b_d0 = 8'h00; b_d1 = 8'h00;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_busy", a_busy, 1'b0);
    chk("rst_bus", a_bus, 8'h00);
    chk("rst_gid", a_gid, 1'b0);
    chk("rst_strobes", {a_load, a_br, a_tb}, 3'b000);
    chk("rst_ready", {a_r1, a_r0}, 2'b00);
    a_v0 = 1'b0;
    rst_b = 1'b0;

    // single byte, FRAME_CYCLES=8
    @(negedge clk);
    a_v0 = 1'b1; a_d0 = 8'h61;
    #1 chk("t1_ready", {a_r1, a_r0}, 2'b01);
    nb = 0; nl = 0; nbr = 0; nt = 0; ndb = 0; il = -1; ibr = -1; it = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (i == 0) begin a_v0 = 1'b0; a_d0 = 8'hFF; end
      if (a_busy) nb++;
      if (a_load) begin nl++; il = i; end
      if (a_br) begin nbr++; ibr = i; end
      if (a_tb) begin nt++; it = i; end
      if (a_bus !== 8'h61) ndb++;
      if (a_r0) ndb++;
    end
    chk("t1_load_at", il, 0);
    chk("t1_br_at", ibr, 1);
    chk("t1_tbyte_at", it, 2);
    chk("t1_strobe_cnt", {8'(nl), 8'(nbr), 8'(nt)}, 24'h010101);
    chk("t1_busy_cycles", nb, 11);
    chk("t1_bus_stable", ndb, 0);
    chk("t1_gid", a_gid, 1'b0);

    // round robin with both requesters always valid
    @(negedge clk) rst_b = 1'b1;
    @(negedge clk) rst_b = 1'b0;
    a_v0 = 1'b1; a_v1 = 1'b1; a_d0 = 8'h41; a_d1 = 8'h42;
    n = 0; both = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (a_r0 && a_r1) both++;
      if (a_load) begin
        if (n < 4) begin bytes[n] = a_bus; gids[n] = a_gid; end
        n++;
      end
    end
    a_v0 = 1'b0; a_v1 = 1'b0;
    chk("t2_accepts", n, 4);
    chk("t2_one_hot", both, 0);
    chk("t2_bytes", {bytes[0], bytes[1], bytes[2], bytes[3]}, 32'h41424142);
    chk("t2_gids", {gids[0], gids[1], gids[2], gids[3]}, 4'b0101);
    repeat (15) @(negedge clk);

    // req1 arrives during WAIT and is taken on the first IDLE cycle
    a_v0 = 1'b1; a_d0 = 8'h10;
    @(negedge clk) a_v0 = 1'b0;
    repeat (4) @(negedge clk);
    a_v1 = 1'b1; a_d1 = 8'h5A;
    bad = 0; found = 0;
    for (int i = 0; i < 30 && found == 0; i++) begin
      @(negedge clk);
      #1;
      if (a_busy) begin
        if (a_r1) bad++;
      end else begin
        found = 1;
        chk("t3_ready_idle", a_r1, 1'b1);
      end
    end
    chk("t3_found_idle", found, 1);
    chk("t3_no_early_ready", bad, 0);
    @(negedge clk) a_v1 = 1'b0;
    chk("t3_bus", a_bus, 8'h5A);
    chk("t3_gid", a_gid, 1'b1);
    chk("t3_load", a_load, 1'b1);
    repeat (14) @(negedge clk);

    // req1 withdraws before being granted: nothing is sent for it
    a_v0 = 1'b1; a_d0 = 8'h20;
    @(negedge clk) a_v0 = 1'b0;
    repeat (3) @(negedge clk);
    a_v1 = 1'b1; a_d1 = 8'hEE;
    repeat (3) @(negedge clk);
    a_v1 = 1'b0;
    nl = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (a_load) nl++;
    end
    chk("t4_no_send", nl, 0);
    chk("t4_bus", a_bus, 8'h20);
    chk("t4_gid", a_gid, 1'b0);

    // reset in READY aborts the frame
    a_v0 = 1'b1; a_d0 = 8'h77;
    @(negedge clk) a_v0 = 1'b0;
    chk("t5_load", a_load, 1'b1);
    @(negedge clk);
    chk("t5_ready_state", a_br, 1'b1);
    rst_b = 1'b1;
    @(negedge clk);
    chk("t5_busy", a_busy, 1'b0);
    chk("t5_bus", a_bus, 8'h00);
    chk("t5_gid", a_gid, 1'b0);
    chk("t5_strobes", {a_load, a_br, a_tb}, 3'b000);
    rst_b = 1'b0;
    nt = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (a_tb || a_load || a_busy) nt++;
    end
    chk("t5_no_resend", nt, 0);
    a_v0 = 1'b1; a_v1 = 1'b1;
    #1 chk("t5_req0_favoured", {a_r1, a_r0}, 2'b01);
    a_v0 = 1'b0; a_v1 = 1'b0;

`ifdef UART_TX_SCHED_CNT_EN
    // tx_count wrap
    @(negedge clk);
    chk("t6_cnt_rst", a_txc, 16'h0000);
    force u_d8.tx_cnt_q = 16'hFFFF;
    @(negedge clk);
    release u_d8.tx_cnt_q;
    a_v0 = 1'b1; a_d0 = 8'h55;
    @(negedge clk) a_v0 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("t6_start", a_tb, 1'b1);
    chk("t6_cnt_pre", a_txc, 16'hFFFF);
    @(negedge clk);
    chk("t6_cnt_wrap", a_txc, 16'h0000);
`endif

    // FRAME_CYCLES=1 back-to-back from req0
    b_v0 = 1'b1; b_d0 = 8'h33;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (b_load) begin
        if (n < 3) pos[n] = i;
        n++;
      end
    end
    b_v0 = 1'b0;
    chk("t7_loads", n, 4);
    chk("t7_gap0", pos[1] - pos[0], 5);
    chk("t7_gap1", pos[2] - pos[1], 5);
    chk("t7_bus", b_bus, 8'h33);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
